daq_multihit: RTL and testbench

Parametrised successor to the single-stop cosmic DAQ core. Detects a muon-stop coincidence on the s1/sg/s2 scintillator inputs and vetoes through-going muons. Records up to MAX_HITS sg stop times per event with a CNT_W-bit cycle TDC, and streams tagged words through an internal FIFO with a valid/ready interface. It sits between the pad synchronisers and the readout/UART packer.

---
 rtl/daq_multihit.sv | 214 +++++++++++++++++++++
 tb/tb_daq_multihit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/daq_multihit.sv
// Muon-stop DAQ core: synchronised s1/sg/s2 coincidence FSM, multi-hit cycle TDC
// and a first-word-fall-through output FIFO with valid/ready handshake.
module daq_multihit #(
    parameter int CNT_W     = 16,
    parameter int MAX_HITS  = 4,
    parameter int FIFO_LOG2 = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s1,
    input  logic             sg,
    input  logic             s2,
    input  logic [CNT_W-1:0] delS1_SIZE,
    input  logic [CNT_W-1:0] delS2_SIZE,
    input  logic [CNT_W-1:0] FAKESTOP_SIZE,
    output logic [CNT_W+1:0] tdc_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             trig_out,
    output logic             busy,
    output logic [7:0]       drop_cnt
);

    // state | meaning
    // IDLE  | waiting for s1
    // ARM   | s1 seen, waiting for sg inside delS1 window
    // RUN   | stop timing: s2 veto window, then sg hits
    // END   | writing the trailer word
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_END  = 2'd3;

    localparam int                 DEPTH   = 1 << FIFO_LOG2;
    localparam logic [FIFO_LOG2:0] DEPTH_C = (FIFO_LOG2+1)'(DEPTH);
    localparam logic [FIFO_LOG2:0] NEED_C  = (FIFO_LOG2+1)'(MAX_HITS + 1);
    localparam logic [3:0]         MAX_C   = 4'(MAX_HITS);
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;

    logic [2:0] s1_sync_q, sg_sync_q, s2_sync_q;
    logic       p_s1, p_sg, p_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_sync_q <= '0;
            sg_sync_q <= '0;
            s2_sync_q <= '0;
        end else begin
            s1_sync_q <= {s1_sync_q[1:0], s1};
            sg_sync_q <= {sg_sync_q[1:0], sg};
            s2_sync_q <= {s2_sync_q[1:0], s2};
        end
    end

    assign p_s1 = s1_sync_q[1] & ~s1_sync_q[2];
    assign p_sg = sg_sync_q[1] & ~sg_sync_q[2];
    assign p_s2 = s2_sync_q[1] & ~s2_sync_q[2];

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     win_q, win_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           hits_q, hits_d, hits_inc;
    logic [1:0]           tag_q, tag_d;
    logic                 trig_q, trig_d;
    logic [7:0]           drop_q, drop_d;
    logic                 start_chk, hit, space_ok;
    logic                 push;
    logic [CNT_W+1:0]     push_data;

    logic [CNT_W+1:0]     mem_q [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr_q, rd_ptr_q, rd_nxt;
    logic [FIFO_LOG2:0]   count_q, count_d;
    logic [CNT_W+1:0]     head_q, head_d;
    logic                 pop, full, wr_en;

    assign space_ok = (DEPTH_C - count_q) >= NEED_C;

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        cnt_d     = cnt_q;
        hits_d    = hits_q;
        tag_d     = tag_q;
        trig_d    = 1'b0;
        drop_d    = drop_q;
        start_chk = 1'b0;
        hit       = 1'b0;
        hits_inc  = hits_q + 4'd1;
        push      = 1'b0;
        push_data = '0;
        case (state_q)
            ST_IDLE: begin
                if (p_s1) begin
                    state_d   = ST_ARM;
                    win_d     = '0;
                    start_chk = p_sg;
                end
            end
            ST_ARM: begin
                if (p_sg && (win_q < delS1_SIZE)) begin
                    start_chk = 1'b1;
                end else if (p_s1) begin
                    win_d = '0;
                end else if (win_q >= delS1_SIZE) begin
                    state_d = ST_IDLE;
                end else begin
                    win_d = win_q + 1'b1;
                end
            end
            ST_RUN: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                // A veto inside the window outranks both sg and the timeout.
                if (p_s2 && (cnt_q < delS2_SIZE)) begin
                    state_d = ST_IDLE;
                end else begin
                    hit = p_sg && (cnt_q >= delS2_SIZE);
                    if (hit) begin
                        push      = 1'b1;
                        push_data = {2'b01, cnt_q};
                        hits_d    = hits_inc;
                    end
                    if (cnt_q == FAKESTOP_SIZE) begin
                        state_d = ST_END;
                        tag_d   = 2'b11;
                    end else if (hit && (hits_inc == MAX_C)) begin
                        state_d = ST_END;
                        tag_d   = 2'b10;
                    end
                end
            end
            default: begin
                push      = 1'b1;
                push_data = {tag_q, {(CNT_W-4){1'b0}}, hits_q};
                state_d   = ST_IDLE;
            end
        endcase
        if (start_chk) begin
            if (space_ok) begin
                state_d = ST_RUN;
                cnt_d   = '0;
                hits_d  = '0;
                trig_d  = 1'b1;
            end else begin
                state_d = ST_IDLE;
                if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            cnt_q   <= '0;
            hits_q  <= '0;
            tag_q   <= '0;
            trig_q  <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            hits_q  <= hits_d;
            tag_q   <= tag_d;
            trig_q  <= trig_d;
            drop_q  <= drop_d;
        end
    end

    assign data_valid = (count_q != '0);
    assign full       = (count_q == DEPTH_C);
    assign pop        = data_valid && data_ready;
    assign wr_en      = push && (!full || pop);
    assign rd_nxt     = rd_ptr_q + 1'b1;

    // head_q mirrors the FIFO head so the output is reset and holds when empty.
    always_comb begin
        head_d = head_q;
        if (pop && (count_q > (FIFO_LOG2+1)'(1))) begin
            head_d = mem_q[rd_nxt];
        end else if (wr_en && ((count_q == '0) || (pop && (count_q == (FIFO_LOG2+1)'(1))))) begin
            head_d = push_data;
        end
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_nxt;
            count_q <= count_d;
            head_q  <= head_d;
        end
    end

    assign tdc_out  = head_q;
    assign trig_out = trig_q;
    assign busy     = (state_q != ST_IDLE);
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_daq_multihit.sv
// Randomised and directed bench for daq_multihit; expected FIFO words, trigger and
// drop counts come from an event-level arithmetic model of the stop rules.
module tb_daq_multihit;
    localparam int CNT_W     = 16;
    localparam int MAX_HITS  = 4;
    localparam int FIFO_LOG2 = 4;
    localparam int DEPTH     = 1 << FIFO_LOG2;

    logic             clk = 1'b0;
    logic             rst;
    logic             s1, sg, s2;
    logic [CNT_W-1:0] delS1_SIZE, delS2_SIZE, FAKESTOP_SIZE;
    logic [CNT_W+1:0] tdc_out;
    logic             data_valid, data_ready, trig_out, busy;
    logic [7:0]       drop_cnt;

    daq_multihit #(.CNT_W(CNT_W), .MAX_HITS(MAX_HITS), .FIFO_LOG2(FIFO_LOG2)) dut (
        .clk(clk), .rst(rst), .s1(s1), .sg(sg), .s2(s2),
        .delS1_SIZE(delS1_SIZE), .delS2_SIZE(delS2_SIZE), .FAKESTOP_SIZE(FAKESTOP_SIZE),
        .tdc_out(tdc_out), .data_valid(data_valid), .data_ready(data_ready),
        .trig_out(trig_out), .busy(busy), .drop_cnt(drop_cnt)
    );

    always #1 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [CNT_W+1:0] exp_q[$];
    int exp_drop = 0;
    int hit_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Words one accepted event leaves in the FIFO, from hit times in cnt units.
    task automatic model_words(input int d2, input int fk, input int s2v);
        int hs[$];
        int n;
        int tag;
        hs  = hit_q;
        hs.sort();
        n   = 0;
        tag = 3;
        if (s2v >= 0 && s2v < d2 && s2v <= fk) return;
        foreach (hs[i]) begin
            if (hs[i] < d2) continue;
            if (hs[i] > fk) break;
            exp_q.push_back({2'b01, 16'(hs[i])});
            n++;
            if (n == MAX_HITS) begin
                tag = (hs[i] == fk) ? 3 : 2;
                break;
            end
        end
        exp_q.push_back({2'(tag), 16'(n)});
    endtask

    // Offsets: s1 at 0, optional s1 restart at r, start sg at d, hit/veto at d+1+cnt.
    task automatic run_event(input int d1, input int d2, input int fk, input int d,
                             input int r, input int s2v, input string name);
        int started, trig_exp, trig_seen, maxoff, t_end;
        delS1_SIZE    = 16'(d1);
        delS2_SIZE    = 16'(d2);
        FAKESTOP_SIZE = 16'(fk);
        if (r > 0 && d > r) started = (d - r <= d1);
        else                started = (d <= d1);
        trig_exp = 0;
        if (started) begin
            if (DEPTH - exp_q.size() >= MAX_HITS + 1) begin
                trig_exp = 1;
                model_words(d2, fk, s2v);
            end else if (exp_drop < 255) begin
                exp_drop++;
            end
        end
        maxoff = fk + 2;
        foreach (hit_q[i]) if (hit_q[i] > maxoff) maxoff = hit_q[i];
        if (s2v > maxoff) maxoff = s2v;
        t_end = d + 1 + maxoff + 10;
        trig_seen = 0;
        for (int t = 0; t <= t_end; t++) begin
            @(negedge clk);
            if (trig_out) trig_seen++;
            s1 = (t == 0) || (r > 0 && t == r);
            sg = (t == d);
            foreach (hit_q[i]) if (t == d + 1 + hit_q[i]) sg = 1'b1;
            s2 = (s2v >= 0) && (t == d + 1 + s2v);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (trig_out) trig_seen++;
            s1 = 1'b0; sg = 1'b0; s2 = 1'b0;
        end
        chk({name, ".trig"}, 32'(trig_seen), 32'(trig_exp));
        chk({name, ".busy"}, 32'(busy), 32'd0);
        chk({name, ".drop"}, 32'(drop_cnt), 32'(exp_drop));
        chk({name, ".valid"}, 32'(data_valid), 32'(exp_q.size() != 0));
    endtask

    task automatic drain(input string name);
        for (int k = 0; k <= DEPTH + 2; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                data_ready = 1'b0;
                chk({name, ".empty"}, 32'(data_valid), 32'd0);
                break;
            end
            chk({name, ".dv"}, 32'(data_valid), 32'd1);
            chk({name, ".word"}, 32'(tdc_out), 32'(exp_q.pop_front()));
            data_ready = 1'b1;
        end
        data_ready = 1'b0;
    endtask

    initial begin
        int d1, d2, fk, d, r, s2v, nh, c;
        rst = 1'b1; s1 = 1'b0; sg = 1'b0; s2 = 1'b0; data_ready = 1'b0;
        delS1_SIZE = 16'd25; delS2_SIZE = 16'd25; FAKESTOP_SIZE = 16'd4000;
        repeat (3) @(negedge clk);
        chk("rst.tdc", 32'(tdc_out), 32'd0);
        chk("rst.dv", 32'(data_valid), 32'd0);
        chk("rst.trig", 32'(trig_out), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.drop", 32'(drop_cnt), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        hit_q.delete();
        run_event(25, 25, 4000, 16, 0, -1, "timeout");
        drain("timeout");
        hit_q = '{800};
        run_event(25, 25, 1000, 16, 0, -1, "onehit");
        drain("onehit");
        hit_q = '{30};
        run_event(25, 25, 200, 16, 0, 10, "veto");
        drain("veto");
        hit_q = '{30, 60, 90, 120, 150};
        run_event(25, 25, 400, 16, 0, -1, "maxhits");
        drain("maxhits");
        hit_q.delete();
        run_event(25, 25, 100, 26, 0, -1, "nosg");
        run_event(25, 25, 60, 25, 0, -1, "edge_d1");
        run_event(25, 25, 60, 0, 0, -1, "same_cyc");
        hit_q = '{25, 60};
        run_event(25, 25, 60, 5, 0, 24, "hit_at_to");
        drain("edges");

        hit_q = '{30, 60, 90, 120};
        for (int e = 0; e < 4; e++) run_event(25, 25, 400, 16, 0, -1, "fill");
        drain("fill");

        hit_q = '{30};
        run_event(25, 25, 100, 16, 0, -1, "pre_rst");
        delS1_SIZE = 16'd25; delS2_SIZE = 16'd25; FAKESTOP_SIZE = 16'd4000;
        @(negedge clk) s1 = 1'b1;
        @(negedge clk) s1 = 1'b0;
        @(negedge clk) sg = 1'b1;
        @(negedge clk) sg = 1'b0;
        repeat (20) @(negedge clk);
        chk("run.busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #0.5;
        chk("midrst.tdc", 32'(tdc_out), 32'd0);
        chk("midrst.dv", 32'(data_valid), 32'd0);
        chk("midrst.trig", 32'(trig_out), 32'd0);
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.drop", 32'(drop_cnt), 32'd0);
        exp_q.delete();
        exp_drop = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        hit_q = '{40, 41 + 2};
        run_event(25, 25, 100, 16, 0, -1, "post_rst");
        drain("post_rst");

        for (int e = 0; e < 40; e++) begin
            d1 = $urandom_range(0, 30);
            d2 = $urandom_range(0, 40);
            fk = $urandom_range(20, 150);
            d  = ($urandom_range(0, 9) < 7) ? $urandom_range(0, d1) : $urandom_range(d1 + 1, d1 + 3);
            r  = (d1 >= 2 && $urandom_range(0, 2) == 0) ? $urandom_range(2, d1) : 0;
            s2v = ($urandom_range(0, 9) < 4) ? $urandom_range(0, d2 + 5) : -1;
            nh = $urandom_range(0, 6);
            c  = $urandom_range(1, 10);
            hit_q.delete();
            for (int h = 0; h < nh; h++) begin
                hit_q.push_back(c);
                c += $urandom_range(2, 40);
            end
            run_event(d1, d2, fk, d, r, s2v, "rnd");
            if ($urandom_range(0, 1) == 1) drain("rnd");
        end
        drain("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
